// File: rtl/sd_spi_responder.sv
// SPI-mode SD card target: decodes 6-byte command frames on MOSI and returns
// R1/R3/R7 responses on MISO. All SPI pins are oversampled on CLOCK_50.
module sd_spi_responder #(
  parameter int          RESP_DELAY  = 1,
  parameter int          ACMD41_BUSY = 2,
  parameter bit          CRC_EN      = 1'b1,
  parameter logic [31:0] OCR         = 32'hC0FF8000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        SPI_SCLK,
  input  logic        SPI_MOSI,
  input  logic        SPI_SS_n,
  output logic        SPI_MISO,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        crc_err,
  output logic        in_idle
);

  typedef enum logic [2:0] {HUNT, CMD, EXEC, WAIT, RESP} state_t;

  typedef struct packed {
    logic [1:0]  start;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic        stop;
  } frame_t;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  state_t      state;
  frame_t      frame;
  logic [1:0]  sclk_sync, mosi_sync, ss_sync;
  logic        sclk_d, ss_d;
  logic        sclk_rise, sclk_fall, ss_n_s, ss_fall, byte_done;
  logic [7:0]  shreg, rx_byte;
  logic [2:0]  bit_cnt, byte_cnt, resp_last;
  logic [39:0] resp_sr;
  logic        app_pending;
  logic [7:0]  acmd_cnt;

  assign ss_n_s    = ss_sync[1];
  assign ss_fall   = ~ss_n_s & ss_d;
  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign rx_byte   = {shreg[6:0], mosi_sync[1]};
  assign byte_done = sclk_rise & (bit_cnt == 3'd7);

  // Decode of the captured frame; only registered in EXEC.
  logic        crc_bad, idle_n, app_n;
  logic [7:0]  cnt_n, r1;
  logic [31:0] tail;
  logic [2:0]  last_n;

  always_comb begin
    crc_bad = CRC_EN && (frame.crc != crc7(frame[47:8]));
    idle_n  = in_idle;
    app_n   = 1'b0;
    cnt_n   = acmd_cnt;
    last_n  = 3'd0;
    tail    = 32'hFFFF_FFFF;
    r1      = 8'h04 | {7'b0, in_idle};
    if (crc_bad) begin
      r1 = 8'h08 | {7'b0, in_idle};
    end else begin
      case (frame.idx)
        6'd0: begin
          idle_n = 1'b1;
          cnt_n  = '0;
          r1     = 8'h01;
        end
        6'd8: begin
          r1     = {7'b0, in_idle};
          tail   = {20'h0, frame.arg[11:0]};
          last_n = 3'd4;
        end
        6'd55: begin
          app_n = 1'b1;
          r1    = {7'b0, in_idle};
        end
        6'd41: begin
          if (app_pending) begin
            if (acmd_cnt < 8'(ACMD41_BUSY)) begin
              cnt_n = acmd_cnt + 8'd1;
              r1    = 8'h01;
            end else begin
              idle_n = 1'b0;
              r1     = 8'h00;
            end
          end
        end
        6'd58: begin
          r1     = {7'b0, in_idle};
          tail   = OCR;
          last_n = 3'd4;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= HUNT;
      frame       <= '0;
      sclk_sync   <= 2'b00;
      mosi_sync   <= 2'b00;
      ss_sync     <= 2'b11;
      sclk_d      <= 1'b0;
      ss_d        <= 1'b1;
      shreg       <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      resp_last   <= '0;
      resp_sr     <= '1;
      app_pending <= 1'b0;
      acmd_cnt    <= '0;
      SPI_MISO    <= 1'b1;
      cmd_valid   <= 1'b0;
      cmd_index   <= '0;
      cmd_arg     <= '0;
      crc_err     <= 1'b0;
      in_idle     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], SPI_SCLK};
      mosi_sync <= {mosi_sync[0], SPI_MOSI};
      ss_sync   <= {ss_sync[0], SPI_SS_n};
      sclk_d    <= sclk_sync[1];
      ss_d      <= ss_sync[1];
      cmd_valid <= 1'b0;
      // Deselect aborts any frame or response; card status survives.
      if (ss_n_s) begin
        state    <= HUNT;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        SPI_MISO <= 1'b1;
      end else if (ss_fall) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else begin
        if (sclk_rise) begin
          shreg   <= rx_byte;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (state != RESP) SPI_MISO <= 1'b1;
        case (state)
          HUNT: if (byte_done && rx_byte[7:6] == 2'b01) begin
            frame    <= frame_t'({40'h0, rx_byte});
            byte_cnt <= 3'd1;
            state    <= CMD;
          end
          CMD: if (byte_done) begin
            frame <= frame_t'({frame[39:0], rx_byte});
            if (byte_cnt == 3'd5) begin
              byte_cnt <= '0;
              state    <= EXEC;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
          EXEC: begin
            cmd_valid   <= 1'b1;
            cmd_index   <= frame.idx;
            cmd_arg     <= frame.arg;
            crc_err     <= crc_bad;
            in_idle     <= idle_n;
            acmd_cnt    <= cnt_n;
            app_pending <= app_n;
            resp_sr     <= {r1, tail};
            resp_last   <= last_n;
            state       <= WAIT;
          end
          WAIT: if (byte_done) begin
            if (byte_cnt == 3'(RESP_DELAY - 1)) begin
              byte_cnt <= '0;
              state    <= RESP;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
          RESP: begin
            // First falling event here follows the last filler's 8th bit.
            if (sclk_fall) begin
              SPI_MISO <= resp_sr[39];
              resp_sr  <= {resp_sr[38:0], 1'b1};
            end
            if (byte_done) begin
              if (byte_cnt == resp_last) begin
                byte_cnt <= '0;
                state    <= HUNT;
              end else begin
                byte_cnt <= byte_cnt + 3'd1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: init sequence, CRC handling, illegal
// commands, chip-select abort and mid-frame reset. A CRC_EN=0 copy shares the bus.
module tb_sd_spi_responder;

  localparam int HALF = 8;
  localparam logic [47:0] F_CMD0   = 48'h40_00000000_95;
  localparam logic [47:0] F_CMD0B  = 48'h40_00000000_94;
  localparam logic [47:0] F_CMD0E  = 48'h40_00000000_00;
  localparam logic [47:0] F_CMD8   = 48'h48_000001AA_87;
  localparam logic [47:0] F_CMD55  = 48'h77_00000000_65;
  localparam logic [47:0] F_ACMD41 = 48'h69_40000000_77;
  localparam logic [47:0] F_CMD58  = 48'h7A_00000000_FD;
  localparam logic [47:0] F_CMD17  = 48'h51_00000000_55;

  logic        CLOCK_50 = 1'b0, reset, sclk, mosi, ss_n;
  logic        miso, cmd_valid, crc_err, in_idle;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        miso2, cmd_valid2, crc_err2, in_idle2;
  logic [5:0]  cmd_index2;
  logic [31:0] cmd_arg2;
  int          n_cmp = 0, n_err = 0, vcnt = 0;

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) if (cmd_valid) vcnt = vcnt + 1;

  sd_spi_responder dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .SPI_SCLK(sclk), .SPI_MOSI(mosi),
    .SPI_SS_n(ss_n), .SPI_MISO(miso), .cmd_valid(cmd_valid),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .crc_err(crc_err), .in_idle(in_idle)
  );

  sd_spi_responder #(.CRC_EN(1'b0)) dut_nc (
    .CLOCK_50(CLOCK_50), .reset(reset), .SPI_SCLK(sclk), .SPI_MOSI(mosi),
    .SPI_SS_n(ss_n), .SPI_MISO(miso2), .cmd_valid(cmd_valid2),
    .cmd_index(cmd_index2), .cmd_arg(cmd_arg2), .crc_err(crc_err2), .in_idle(in_idle2)
  );

  // One mode-0 byte: MOSI set while SCLK low, MISO captured as SCLK rises.
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] rx2);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge CLOCK_50);
      sclk   = 1'b1;
      rx[i]  = miso;
      rx2[i] = miso2;
      repeat (HALF) @(negedge CLOCK_50);
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [47:0] f, input int n,
                           output logic [63:0] r, output logic [63:0] r2);
    logic [7:0] b, b2;
    r = '0; r2 = '0;
    for (int k = 0; k < 6; k++) xfer(f[47 - 8*k -: 8], b, b2);
    for (int k = 0; k < n; k++) begin
      xfer(8'hFF, b, b2);
      r  = {r[55:0], b};
      r2 = {r2[55:0], b2};
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; sclk = 1'b0; mosi = 1'b1; ss_n = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    n_cmp++; if (miso !== 1'b1) begin n_err++; $display("FAIL rst_miso got %b want 1", miso); end
    n_cmp++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", cmd_valid); end
    n_cmp++; if (cmd_index !== 6'd0) begin n_err++; $display("FAIL rst_index got %0d want 0", cmd_index); end
    n_cmp++; if (cmd_arg !== 32'h0) begin n_err++; $display("FAIL rst_arg got %h want 0", cmd_arg); end
    n_cmp++; if (crc_err !== 1'b0) begin n_err++; $display("FAIL rst_crc got %b want 0", crc_err); end
    n_cmp++; if (in_idle !== 1'b1) begin n_err++; $display("FAIL rst_idle got %b want 1", in_idle); end
    reset = 1'b0;
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic test_cmd0;
    logic [7:0] b, b2;
    logic [63:0] r, r2;
    int v0;
    ss_n = 1'b0;
    repeat (8) @(negedge CLOCK_50);
    for (int k = 0; k < 8; k++) xfer(8'hFF, b, b2);
    v0 = vcnt;
    run_frame(F_CMD0, 2, r, r2);
    n_cmp++; if (r[15:0] !== 16'hFF01) begin n_err++; $display("FAIL cmd0_resp got %h want ff01", r[15:0]); end
    n_cmp++; if (vcnt - v0 !== 1) begin n_err++; $display("FAIL cmd0_valid got %0d want 1", vcnt - v0); end
    n_cmp++; if (cmd_index !== 6'd0 || crc_err !== 1'b0) begin
      n_err++; $display("FAIL cmd0_decode got idx=%0d crc=%b want 0/0", cmd_index, crc_err); end
  endtask

  task automatic test_cmd8;
    logic [63:0] r, r2;
    run_frame(F_CMD8, 6, r, r2);
    n_cmp++; if (r[47:0] !== 48'hFF_01_00_00_01_AA) begin n_err++; $display("FAIL cmd8_resp got %h want ff01000001aa", r[47:0]); end
    n_cmp++; if (cmd_index !== 6'd8 || cmd_arg !== 32'h1AA) begin
      n_err++; $display("FAIL cmd8_decode got idx=%0d arg=%h want 8/000001aa", cmd_index, cmd_arg); end
  endtask

  task automatic test_crc;
    logic [63:0] r, r2;
    run_frame(F_CMD0B, 2, r, r2);
    n_cmp++; if (r[15:0] !== 16'hFF01) begin n_err++; $display("FAIL crc_stopbit got %h want ff01", r[15:0]); end
    run_frame(F_CMD0E, 2, r, r2);
    n_cmp++; if (r[15:0] !== 16'hFF09) begin n_err++; $display("FAIL crc_bad_resp got %h want ff09", r[15:0]); end
    n_cmp++; if (crc_err !== 1'b1) begin n_err++; $display("FAIL crc_err_flag got %b want 1", crc_err); end
    n_cmp++; if (r2[15:0] !== 16'hFF01) begin n_err++; $display("FAIL crc_off_resp got %h want ff01", r2[15:0]); end
    n_cmp++; if (crc_err2 !== 1'b0) begin n_err++; $display("FAIL crc_off_flag got %b want 0", crc_err2); end
  endtask

  task automatic test_illegal;
    logic [63:0] r, r2;
    run_frame(F_ACMD41, 2, r, r2);
    n_cmp++; if (r[15:0] !== 16'hFF05) begin n_err++; $display("FAIL cmd41_noapp got %h want ff05", r[15:0]); end
    n_cmp++; if (cmd_index !== 6'd41) begin n_err++; $display("FAIL cmd41_index got %0d want 41", cmd_index); end
  endtask

  task automatic test_init;
    logic [63:0] r, r2;
    logic [15:0] want;
    for (int k = 0; k < 3; k++) begin
      run_frame(F_CMD55, 2, r, r2);
      n_cmp++; if (r[15:0] !== 16'hFF01) begin n_err++; $display("FAIL init_cmd55_%0d got %h want ff01", k, r[15:0]); end
      run_frame(F_ACMD41, 2, r, r2);
      want = (k < 2) ? 16'hFF01 : 16'hFF00;
      n_cmp++; if (r[15:0] !== want) begin n_err++; $display("FAIL init_acmd41_%0d got %h want %h", k, r[15:0], want); end
      n_cmp++; if (in_idle !== (k < 2)) begin n_err++; $display("FAIL init_idle_%0d got %b want %b", k, in_idle, k < 2); end
    end
    run_frame(F_CMD58, 6, r, r2);
    n_cmp++; if (r[47:0] !== 48'hFF_00_C0FF8000) begin n_err++; $display("FAIL cmd58_resp got %h want ff00c0ff8000", r[47:0]); end
    run_frame(F_CMD17, 2, r, r2);
    n_cmp++; if (r[15:0] !== 16'hFF04) begin n_err++; $display("FAIL cmd17_resp got %h want ff04", r[15:0]); end
  endtask

  task automatic test_abort;
    logic [7:0] b, b2;
    logic [63:0] r, r2;
    int v0;
    v0 = vcnt;
    for (int k = 0; k < 3; k++) xfer(F_CMD0[47 - 8*k -: 8], b, b2);
    ss_n = 1'b1;
    repeat (16) @(negedge CLOCK_50);
    n_cmp++; if (vcnt !== v0) begin n_err++; $display("FAIL abort_valid got %0d want %0d", vcnt, v0); end
    n_cmp++; if (miso !== 1'b1) begin n_err++; $display("FAIL abort_miso got %b want 1", miso); end
    n_cmp++; if (in_idle !== 1'b0) begin n_err++; $display("FAIL abort_idle got %b want 0", in_idle); end
    ss_n = 1'b0;
    repeat (8) @(negedge CLOCK_50);
    run_frame(F_CMD0, 2, r, r2);
    n_cmp++; if (r[15:0] !== 16'hFF01) begin n_err++; $display("FAIL abort_cmd0 got %h want ff01", r[15:0]); end
    n_cmp++; if (vcnt - v0 !== 1 || in_idle !== 1'b1) begin
      n_err++; $display("FAIL abort_after got valid=%0d idle=%b want 1/1", vcnt - v0, in_idle); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] b, b2;
    logic [63:0] r, r2;
    int v0;
    v0 = vcnt;
    for (int k = 0; k < 3; k++) xfer(F_CMD8[47 - 8*k -: 8], b, b2);
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (8) @(negedge CLOCK_50);
    n_cmp++; if (vcnt !== v0 || cmd_index !== 6'd0) begin
      n_err++; $display("FAIL midrst_valid got valid=%0d idx=%0d want 0/0", vcnt - v0, cmd_index); end
    run_frame(F_CMD0, 2, r, r2);
    n_cmp++; if (r[15:0] !== 16'hFF01) begin n_err++; $display("FAIL midrst_cmd0 got %h want ff01", r[15:0]); end
  endtask

  initial begin
    test_reset;
    test_cmd0;
    test_cmd8;
    test_crc;
    test_illegal;
    test_init;
    test_abort;
    test_reset_midframe;
    ss_n = 1'b1;
    repeat (8) @(negedge CLOCK_50);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sd_spi_responder.md
Name: sd_spi_responder

Overview:
- Synthesizable SPI-mode SD-card target: the card end of the SD SPI link that the board-level SPI master drives.
- Receives 6-byte command frames on SPI_MOSI and returns R1/R3/R7 responses on SPI_MISO.
- Used as a loopback target and as a bench model for bring-up of the master's CMD0/CMD8/ACMD41/CMD58 init sequence without a physical card.
- Every SPI input is oversampled in the CLOCK_50 domain; there is no clocking on SPI_SCLK.

Parameters:
RESP_DELAY, 1, number of 0xFF filler bytes (NCR) between the command frame end and the first response byte; legal range 1..8
ACMD41_BUSY, 2, number of ACMD41 commands answered 0x01 before the first 0x00
CRC_EN, 1, 1 = check the CRC7 of every frame; 0 = ignore the CRC byte
OCR, 32'hC0FF8000, value returned by CMD58

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset  input  1  synchronous reset, active-high
SPI_SCLK  input  1  SPI clock from the master, mode 0, at most CLOCK_50/8
SPI_MOSI  input  1  command data from the master, MSB first
SPI_SS_n  input  1  active-low chip select
SPI_MISO  output  1  response data to the master
cmd_valid  output  1  one-cycle pulse when a complete frame has been decoded
cmd_index  output  6  index of the last decoded command
cmd_arg  output  32  argument of the last decoded command
crc_err  output  1  CRC status of the last decoded frame
in_idle  output  1  card idle-state flag (R1 bit 0)

Behaviour:

Reset, one clock, takes priority over everything:
- SPI_MISO=1, cmd_valid=0, cmd_index=0, cmd_arg=0, crc_err=0, in_idle=1.
- Internal state: FSM=HUNT, bit and byte counters=0, app_pending=0, acmd41 count=0.

Input synchronisation and sampling:
- SPI_SCLK, SPI_MOSI and SPI_SS_n each pass through a 2-flop synchroniser.
- A rising/falling SCLK event is one CLOCK_50 cycle, derived from the synchronised level.
- MOSI is sampled on rising SCLK events and shifted MSB-first into an 8-bit register.
- The bit counter wraps at 8.

Chip select:
- SS_n high: SPI_MISO=1 and FSM held in HUNT.
- Bit and byte counters are cleared on every SS_n rising or falling edge.
- SS_n rising mid-frame or mid-response aborts to HUNT; in_idle, app_pending and the acmd41 count are preserved and no cmd_valid is issued.

FSM states and transitions:
- HUNT: on each completed byte, if byte[7:6]==2'b01, store it as byte 0 and go to CMD; otherwise stay. MISO=1.
- CMD: collect bytes 1..5 (argument MSB first, then the CRC byte). After byte 5 go to EXEC. MISO=1.
- EXEC (exactly 1 CLOCK_50 cycle):
  - CRC7 uses polynomial x^7+x^3+1, init 0, computed over bytes 0..4.
  - Mismatch iff CRC_EN=1 and byte5[7:1] differs from the computed CRC; byte5[0] is ignored.
  - Update cmd_index, cmd_arg and crc_err, and pulse cmd_valid.
  - Build the response, then go to WAIT.
- WAIT: send RESP_DELAY bytes of 0xFF, then go to RESP.
- RESP: shift out the response bytes MSB first, then return to HUNT.

Response bit timing:
- The MSB of each response byte is driven on the falling SCLK event that completes the previous byte's 8th bit.
- Remaining bits are driven on subsequent falling events.
- MISO is valid before every rising event.
- MOSI bytes received during WAIT and RESP are ignored.

Response table (R1 bits: 0x01 idle, 0x04 illegal command, 0x08 CRC error; idle bit = in_idle after the update):
- CRC error: R1 = 0x08|idle; no state changes.
- CMD0: in_idle:=1, acmd41 count:=0, app_pending:=0; R1 = 0x01.
- CMD8: R7 = R1, 0x00, 0x00, {4'h0, arg[11:8]}, arg[7:0] (5 bytes).
- CMD55: app_pending:=1; R1 = idle.
- CMD41 with app_pending=1:
  - If count < ACMD41_BUSY: count++ and R1 = 0x01.
  - Otherwise: in_idle:=0 and R1 = 0x00.
- CMD58: R3 = R1 followed by OCR, MSB byte first (5 bytes).
- Any other index, or CMD41 without app_pending: R1 = 0x04|idle.
- app_pending clears after every decoded command other than CMD55, including on a CRC error.

Boundary conditions:
- Back-to-back frames with no gap are accepted; hunting resumes on the first byte after RESP.
- Reset asserted mid-frame discards the frame with no cmd_valid.

Test Plan:
- Reset, then SS_n low, 8 filler bytes 0xFF, then 40 00 00 00 00 95 -> exactly RESP_DELAY bytes of 0xFF, then 0x01; one cmd_valid with cmd_index=0 and crc_err=0.
- CMD8 48 00 00 01 AA 87 -> FF, 01 00 00 01 AA.
- CMD0 with CRC byte 0x94 -> 0x01 (byte5[0] ignored); CMD0 with CRC byte 0x00 -> 0x09 and crc_err=1; with CRC_EN=0 the same frame -> 0x01.
- Loop of CMD55 (77 00 00 00 00 65) then ACMD41 (69 40 00 00 00 77), ACMD41_BUSY=2 -> ACMD41 responses 01, 01, 00; in_idle falls after the third ACMD41; then CMD58 (7A 00 00 00 00 FD) -> 00 C0 FF 80 00.
- CMD41 without a preceding CMD55 -> 0x05 while in_idle=1; CMD17 after init -> 0x04.
- SS_n raised after byte 3 of CMD0 -> no cmd_valid, MISO=1; reasserting SS_n and sending a full CMD0 -> normal 0x01.
